// File: rtl/adder_ripple.sv
// adder_ripple: registered two's-complement ripple-carry adder, q = a + b.
// The carry chain is built from explicit 1-bit full-adder cells. The result,
// unsigned carry-out and signed overflow are registered once, so latency is
// one clock.
// Optional feature: define ADDER_RIPPLE_SAT_EN for signed saturation of q on
// overflow. The default build leaves the macro undefined and q wraps.

// One full-adder cell: sum = a^b^c, carry = majority(a, b, c).
module adder_ripple_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

module adder_ripple #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_raw_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_q_next;

  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  // The carry into bit 0 is tied low. The chain ripples LSB to MSB with no
  // '+' operator anywhere on the carry path.
  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    adder_ripple_fa u_fa (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_carry[i]),
      .o_s (w_raw_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  // Signed overflow: both operands have the same sign and the sum's sign differs.
  assign w_ovf = (a[MSB] == b[MSB]) && (w_raw_sum[MSB] != a[MSB]);

  // Select the value that q takes next: the wrapped raw sum or, when the feature is built in, the saturated value.
  always_comb begin
    // NOTE: assign a default first so that no path leaves w_q_next unassigned,
    // which would infer a latch.
    w_q_next = w_raw_sum;
`ifdef ADDER_RIPPLE_SAT_EN
    if (w_ovf) begin
      // A positive overflow clamps to the most positive value and a negative overflow clamps to the most negative value.
      w_q_next = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Capture the result on in_valid. The stored result holds when in_valid is low, and out_valid follows in_valid one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for every register so that all
      // flops update together from the values they had before the edge.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_q    <= w_q_next;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign q         = r_q;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_ripple.sv
// tb_adder_ripple: self-checking bench for adder_ripple with WIDTH=4.
// Expected values come from an integer-arithmetic model of the adder. When the
// bench is compiled with ADDER_RIPPLE_SAT_EN, the model also saturates q.
`timescale 1ns/1ps

module tb_adder_ripple;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             ovf;
  logic             out_valid;

  int n_vec;
  int n_err;

  // Last result the DUT should be holding.
  logic [WIDTH-1:0] last_q;
  logic             last_c;
  logic             last_o;

  adder_ripple #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .q         (q),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It computes the unsigned sum, the carry and the signed overflow with plain integer arithmetic.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       output logic [WIDTH-1:0] eq, output logic ec, output logic eo);
    int ua, ub, us, sa, sb, ss;
    ua = int'(ma);
    ub = int'(mb);
    us = ua + ub;
    sa = (ua >= (1 << (WIDTH-1))) ? ua - (1 << WIDTH) : ua;
    sb = (ub >= (1 << (WIDTH-1))) ? ub - (1 << WIDTH) : ub;
    ss = sa + sb;
    ec = (us >= (1 << WIDTH));
    eo = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
    eq = WIDTH'(us % (1 << WIDTH));
`ifdef ADDER_RIPPLE_SAT_EN
    if (eo) eq = (ss > 0) ? WIDTH'((1 << (WIDTH-1)) - 1) : WIDTH'(1 << (WIDTH-1));
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    #1;
    n_vec++;
    if ({q, cout, ovf, out_valid} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: got q=%h c=%b o=%b v=%b, want all zero", q, cout, ovf, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_q = '0; last_c = 1'b0; last_o = 1'b0;
  endtask

  // Directed cases, including the boundaries 0+0 and (-8)+(-8).
  task automatic test_directed();
    logic [WIDTH-1:0] ta [6] = '{4'h4, 4'h4, 4'hC, 4'hC, 4'h0, 4'h8};
    logic [WIDTH-1:0] tb [6] = '{4'h3, 4'h4, 4'hC, 4'hB, 4'h0, 4'h8};
    logic [WIDTH-1:0] eq;
    logic ec, eo;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; in_valid = 1'b1;
      model(ta[i], tb[i], eq, ec, eo);
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if ({q, cout, ovf, out_valid} !== {eq, ec, eo, 1'b1}) begin
        n_err++;
        $display("FAIL directed_%0d a=%h b=%h: got q=%h c=%b o=%b v=%b, want q=%h c=%b o=%b v=1",
                 i, ta[i], tb[i], q, cout, ovf, out_valid, eq, ec, eo);
      end
      last_q = eq; last_c = ec; last_o = eo;
    end
  endtask

  // Pulse reset low in the middle of a cycle while in_valid is high. The outputs must clear at once, and the discarded operation must not produce a result.
  task automatic test_async_reset();
    logic [WIDTH-1:0] eq;
    logic ec, eo;
    @(negedge clk);
    a = 4'h4; b = 4'h3; in_valid = 1'b1;
    model(4'h4, 4'h3, eq, ec, eo);
    @(posedge clk);
    #1;
    n_vec++;
    if ({q, out_valid} !== {eq, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_result: got q=%h v=%b, want q=%h v=1", q, out_valid, eq);
    end
    a = 4'h5; b = 4'h1;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({q, cout, ovf, out_valid} !== 7'b0) begin
      n_err++;
      $display("FAIL async_reset: got q=%h c=%b o=%b v=%b, want all zero", q, cout, ovf, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({q, out_valid} !== {4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_idle: got q=%h v=%b, want q=0 v=0", q, out_valid);
    end
    last_q = '0; last_c = 1'b0; last_o = 1'b0;
  endtask

  // Run the four specification cases on consecutive cycles. out_valid must stay high through them, and the result must then hold after in_valid drops.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] ta [4] = '{4'h4, 4'h4, 4'hC, 4'hC};
    logic [WIDTH-1:0] tb [4] = '{4'h3, 4'h4, 4'hC, 4'hB};
    logic [WIDTH-1:0] eq;
    logic ec, eo;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; in_valid = 1'b1;
      model(ta[i], tb[i], eq, ec, eo);
      @(posedge clk);
      #1;
      n_vec++;
      if ({q, cout, ovf, out_valid} !== {eq, ec, eo, 1'b1}) begin
        n_err++;
        $display("FAIL b2b_%0d: got q=%h c=%b o=%b v=%b, want q=%h c=%b o=%b v=1",
                 i, q, cout, ovf, out_valid, eq, ec, eo);
      end
      last_q = eq; last_c = ec; last_o = eo;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 4'h1; b = 4'h1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({q, cout, ovf, out_valid} !== {last_q, last_c, last_o, 1'b0}) begin
        n_err++;
        $display("FAIL hold_%0d: got q=%h c=%b o=%b v=%b, want q=%h c=%b o=%b v=0",
                 k, q, cout, ovf, out_valid, last_q, last_c, last_o);
      end
    end
  endtask

  // Apply random operands with in_valid gated at random. The idle cycles check that the last result holds.
  task automatic test_random();
    logic [WIDTH-1:0] ra, rb, eq;
    logic ec, eo, v;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      a = ra; b = rb; in_valid = v;
      if (v) begin
        model(ra, rb, eq, ec, eo);
        last_q = eq; last_c = ec; last_o = eo;
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({q, cout, ovf, out_valid} !== {last_q, last_c, last_o, v}) begin
        n_err++;
        $display("FAIL random_%0d a=%h b=%h iv=%b: got q=%h c=%b o=%b v=%b, want q=%h c=%b o=%b v=%b",
                 i, ra, rb, v, q, cout, ovf, out_valid, last_q, last_c, last_o, v);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so that the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000ns");
    $fatal(1);
  end

endmodule
